voq_out_module: RTL and testbench



---
 rtl/voq_out_module.sv | 209 ++++++++++++++++++++
 tb/tb_voq_out_module.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/voq_out_module.sv
// voq_out_module
//   Egress-side reader of a virtual output queue (VOQ) for one output port.
//   Words are popped from the VOQ under a credit rule that keeps the small
//   output buffer (OBUF) from overflowing. Header words are parsed for the
//   destination port and payload length. Frames for this port are forwarded
//   with SOP/EOP markers and ready/valid backpressure. Frames for any other
//   port are consumed and dropped, with a one-cycle err_port pulse.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   voq_empty    VOQ has no word available
//   voq_rd_data  VOQ word {dst, payload}, valid the cycle after voq_rd_en
//   voq_rd_en    pop one VOQ word
//   port_ready   downstream accepts the current word
//   port_valid   port_data/port_sop/port_eop are valid
//   port_data    payload word with the port-select field stripped
//   port_sop     first word of a frame (the header)
//   port_eop     last word of a frame
//   err_port     one-cycle pulse when a header for another port is dropped
//   frame_cnt    frames delivered (EOP handshakes), wraps at 16 bits
module voq_out_module #(
  parameter int NUB             = 0,
  parameter int PORT_NUB        = 8,
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_LENGTH_MAX = 1024,
  parameter int CRC_WIDTH       = 32,
  parameter int PRIORITY        = 8,
  parameter int OBUF_DEPTH      = 4,
  localparam int WIDTH_SEL      = $clog2(PORT_NUB),
  localparam int WIDTH_PORT     = WIDTH_SEL + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  voq_empty,
  input  logic [WIDTH_PORT-1:0] voq_rd_data,
  output logic                  voq_rd_en,
  input  logic                  port_ready,
  output logic                  port_valid,
  output logic [DATA_WIDTH-1:0] port_data,
  output logic                  port_sop,
  output logic                  port_eop,
  output logic                  err_port,
  output logic [15:0]           frame_cnt
);

  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY);
  localparam int LEN_LSB        = CRC_WIDTH + WIDTH_PRIORITY;
  localparam int AW             = $clog2(OBUF_DEPTH);
  localparam int CW             = AW + 1;
  localparam int EW             = DATA_WIDTH + 2;

  typedef enum logic {
    PARSE_HEAD,
    PARSE_BODY
  } parse_state_t;

  // Read side
  logic                    inflight;
  logic                    rd_vld;
  logic [WIDTH_SEL-1:0]    word_dst;
  logic [WIDTH_LENGTH-1:0] word_len;
  logic [DATA_WIDTH-1:0]   word_payload;

  // Parser
  parse_state_t            parse_state;
  logic [WIDTH_LENGTH-1:0] rem;
  logic [WIDTH_LENGTH-1:0] rem_nxt;
  logic                    drop;
  logic                    drop_nxt;
  logic                    err_nxt;
  logic                    push;
  logic                    push_sop;
  logic                    push_eop;

  // Output buffer
  logic [EW-1:0]           obuf_mem [OBUF_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           obuf_count;
  logic [EW-1:0]           obuf_head;
  logic                    obuf_nonempty;
  logic                    pop;

  assign rd_vld       = inflight;
  assign word_dst     = voq_rd_data[WIDTH_PORT-1 -: WIDTH_SEL];
  assign word_len     = voq_rd_data[LEN_LSB+WIDTH_LENGTH-1 : LEN_LSB];
  assign word_payload = voq_rd_data[DATA_WIDTH-1:0];

  // A read is only issued when a buffer slot is reserved for it: words already
  // buffered plus the word returning this cycle must leave room. Same-cycle
  // pops are deliberately not credited, which keeps this path off port_ready.
  assign voq_rd_en = rst_n && !voq_empty &&
                     (({1'b0, obuf_count} + (CW+1)'(inflight)) < (CW+1)'(OBUF_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= voq_rd_en;
    end
  end

  // A zero remaining-count means the next returned word is a header.
  assign parse_state = (rem == '0) ? PARSE_HEAD : PARSE_BODY;

  always_comb begin
    rem_nxt  = rem;
    drop_nxt = drop;
    err_nxt  = 1'b0;
    push     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    if (rd_vld) begin
      unique case (parse_state)
        PARSE_HEAD: begin
          rem_nxt  = word_len;
          push_sop = 1'b1;
          push_eop = (word_len == '0);
          if (word_dst == WIDTH_SEL'(NUB)) begin
            push     = 1'b1;
            drop_nxt = 1'b0;
          end else begin
            // A header-only frame has no body to skip, so DROP stays clear.
            drop_nxt = (word_len != '0);
            err_nxt  = 1'b1;
          end
        end
        PARSE_BODY: begin
          rem_nxt  = rem - WIDTH_LENGTH'(1);
          push_eop = (rem == WIDTH_LENGTH'(1));
          push     = !drop;
          if (rem == WIDTH_LENGTH'(1)) begin
            drop_nxt = 1'b0;
          end
        end
        default: begin
          rem_nxt = rem;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem      <= '0;
      drop     <= 1'b0;
      err_port <= 1'b0;
    end else begin
      rem      <= rem_nxt;
      drop     <= drop_nxt;
      err_port <= err_nxt;
    end
  end

  // Show-ahead FIFO: the head entry drives the outputs directly.
  assign obuf_nonempty = (obuf_count != '0);
  assign obuf_head     = obuf_mem[rd_ptr];
  assign pop           = obuf_nonempty && port_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      obuf_mem[wr_ptr] <= {push_sop, push_eop, word_payload};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      obuf_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   obuf_count <= obuf_count + CW'(1);
        2'b01:   obuf_count <= obuf_count - CW'(1);
        default: obuf_count <= obuf_count;
      endcase
    end
  end

  // The read credit rule should make a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (obuf_count == CW'(OBUF_DEPTH))));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pop && obuf_head[EW-2]) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Stale buffer contents are masked so idle outputs read as zero.
  assign port_valid = obuf_nonempty;
  assign port_sop   = obuf_nonempty && obuf_head[EW-1];
  assign port_eop   = obuf_nonempty && obuf_head[EW-2];
  assign port_data  = obuf_nonempty ? obuf_head[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_voq_out_module.sv
// tb_voq_out_module
//   Testbench for voq_out_module with NUB=3. The VOQ is modelled as a queue
//   of words with one-cycle read latency. Each frame sent is also turned into
//   the list of beats the port should deliver (or into an expected err_port
//   pulse when addressed elsewhere), and delivered beats are matched in order.
module tb_voq_out_module;

  localparam int NUB        = 3;
  localparam int DATA_WIDTH = 64;
  localparam int WP         = 3 + DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          voq_empty = 1'b1;
  logic [WP-1:0] voq_rd_data = '0;
  logic          voq_rd_en;
  logic          port_ready = 1'b0;
  logic          port_valid;
  logic [63:0]   port_data;
  logic          port_sop;
  logic          port_eop;
  logic          err_port;
  logic [15:0]   frame_cnt;

  logic [WP-1:0] voq_q [$];
  logic [65:0]   exp_q [$];
  int            tests = 0;
  int            failed = 0;
  int            err_seen = 0;
  int            exp_err = 0;
  int            exp_frames = 0;
  int            beats = 0;
  bit            empty_gate = 1'b0;

  always #5 clk = ~clk;

  voq_out_module #(
    .NUB             (NUB),
    .PORT_NUB        (8),
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_LENGTH_MAX (1024),
    .CRC_WIDTH       (32),
    .PRIORITY        (8),
    .OBUF_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .voq_empty   (voq_empty),
    .voq_rd_data (voq_rd_data),
    .voq_rd_en   (voq_rd_en),
    .port_ready  (port_ready),
    .port_valid  (port_valid),
    .port_data   (port_data),
    .port_sop    (port_sop),
    .port_eop    (port_eop),
    .err_port    (err_port),
    .frame_cnt   (frame_cnt)
  );

  task automatic check_output(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one frame into the VOQ and record what the port should produce.
  // Header length sits in bits [44:35]; body words carry random dst bits
  // that must be ignored and stripped.
  task automatic send_frame(input int dst, input int len);
    logic [63:0] w;
    logic [2:0]  d;
    w = {$urandom, $urandom};
    w[44:35] = 10'(len);
    d = 3'(dst);
    voq_q.push_back({d, w});
    if (dst == NUB) exp_q.push_back({1'b1, 1'(len == 0), w});
    else exp_err++;
    for (int i = 1; i <= len; i++) begin
      w = {$urandom, $urandom};
      d = 3'($urandom);
      voq_q.push_back({d, w});
      if (dst == NUB) exp_q.push_back({1'b0, 1'(i == len), w});
    end
    if (dst == NUB) exp_frames++;
  endtask

  // One clock cycle, entered and left at a falling edge. Outputs are sampled
  // just after the falling edge; the VOQ returns a popped word just after
  // the rising edge at which voq_rd_en was seen.
  task automatic apply_stimulus();
    logic        rd_en;
    logic [65:0] beat;
    voq_empty = empty_gate || (voq_q.size() == 0);
    #1;
    rd_en = voq_rd_en;
    if (voq_empty) check_output("rd_en_while_empty", 66'(rd_en), 66'(0));
    if (err_port) err_seen++;
    if (port_valid && port_ready) begin
      beats++;
      beat = {port_sop, port_eop, port_data};
      check_output("beat_expected", 66'(exp_q.size() != 0), 66'(1));
      if (exp_q.size() != 0) check_output("beat", beat, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rd_en && voq_q.size() != 0) voq_rd_data = voq_q.pop_front();
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    port_ready = 1'b1;
    empty_gate = 1'b0;
    while ((exp_q.size() != 0 || voq_q.size() != 0) && budget < 2000) begin
      apply_stimulus();
      budget++;
    end
    check_output({tag, "_drain_in_time"}, 66'(budget < 2000), 66'(1));
    run_cycles(4);
    check_output({tag, "_beats_left"}, 66'(exp_q.size()), 66'(0));
    check_output({tag, "_voq_left"}, 66'(voq_q.size()), 66'(0));
    check_output({tag, "_frame_cnt"}, 66'(frame_cnt), 66'(exp_frames % 65536));
    check_output({tag, "_err_pulses"}, 66'(err_seen), 66'(exp_err));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    port_ready = 1'b0;
    empty_gate = 1'b1;
    voq_q.delete();
    exp_q.delete();
    run_cycles(n);
    rst_n = 1'b1;
    #1;
    check_output("rst_voq_rd_en", 66'(voq_rd_en), 66'(0));
    check_output("rst_port_valid", 66'(port_valid), 66'(0));
    check_output("rst_port_data", 66'(port_data), 66'(0));
    check_output("rst_port_sop", 66'(port_sop), 66'(0));
    check_output("rst_port_eop", 66'(port_eop), 66'(0));
    check_output("rst_err_port", 66'(err_port), 66'(0));
    check_output("rst_frame_cnt", 66'(frame_cnt), 66'(0));
    exp_frames = 0;
    exp_err = 0;
    err_seen = 0;
    empty_gate = 1'b0;
  endtask

  initial begin
    int b;
    do_reset(2);

    // Three-word frame, then a header-only frame.
    port_ready = 1'b1;
    send_frame(3, 2);
    drain("t1");
    send_frame(3, 0);
    drain("t2");

    // Backpressure: the buffer fills with 4 words and reads stop.
    port_ready = 1'b0;
    send_frame(3, 7);
    run_cycles(10);
    check_output("t3_voq_words_left", 66'(voq_q.size()), 66'(4));
    check_output("t3_rd_en_stalled", 66'(voq_rd_en), 66'(0));
    check_output("t3_valid_held", 66'(port_valid), 66'(1));
    check_output("t3_sop_at_head", 66'(port_sop), 66'(1));
    port_ready = 1'b1;
    b = beats;
    run_cycles(8);
    check_output("t3_back_to_back", 66'(beats - b), 66'(8));
    drain("t3");

    // Frame for another port, followed by a good one.
    send_frame(5, 3);
    send_frame(3, 2);
    drain("t4");

    // VOQ running dry every other cycle in the middle of a frame.
    send_frame(3, 5);
    port_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      empty_gate = ~empty_gate;
      apply_stimulus();
    end
    drain("t5");

    // Reset in the middle of a frame, then a fresh frame.
    send_frame(3, 7);
    port_ready = 1'b1;
    run_cycles(4);
    do_reset(1);
    send_frame(3, 1);
    drain("t6");

    // Random mix of destinations, lengths, backpressure and VOQ gaps.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 0) send_frame(NUB, int'($urandom_range(0, 9)));
      else send_frame(int'($urandom_range(4, 7)), int'($urandom_range(0, 9)));
    end
    for (int i = 0; i < 300; i++) begin
      port_ready = 1'($urandom_range(0, 3) != 0);
      empty_gate = 1'($urandom_range(0, 3) == 0);
      apply_stimulus();
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
